// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 command-FIFO serializer: FSM states,
// FIFO word field positions and the idle levels of the three bus wires.
package tm1638_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_BIT_LOW  = 3'd2,
    S_BIT_HIGH = 3'd3,
    S_NEXT     = 3'd4,
    S_STB_END  = 3'd5,
    S_GAP      = 3'd6
  } tm_state_e;

  localparam int TM_BYTE_LSB = 0;
  localparam int TM_BYTE_MSB = 7;
  localparam int TM_LAST_BIT = 8;

  localparam logic TM_STB_IDLE = 1'b1;
  localparam logic TM_CLK_IDLE = 1'b1;
  localparam logic TM_DIO_IDLE = 1'b1;

endpackage

// File: rtl/tm1638_half_bit_timer.sv
// Loadable down-counter that paces TM1638 bus phases. Loading value N makes
// o_Tick rise after N further cycles, so a phase lasting D cycles loads D-1.
module tm1638_half_bit_timer #(
  parameter int MAX_COUNT = 16,
  localparam int W = $clog2(MAX_COUNT + 1)
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Value,
  output logic         o_Tick
);

  logic [W-1:0] r_Count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Count <= '0;
    end else if (i_Load) begin
      r_Count <= i_Load_Value;
    end else if (r_Count != '0) begin
      r_Count <= r_Count - 1'b1;
    end
  end

  assign o_Tick = (r_Count == '0);

endmodule

// File: rtl/tm1638_fifo_tx.sv
// Drains the command FIFO and shifts each byte LSB first onto the TM1638
// STB/CLK/DIO wires. Bytes whose "last" flag is clear keep STB low so that
// multi-byte commands go out as one frame.
module tm1638_fifo_tx
  import tm1638_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int CLK_DIV    = 8,
  parameter int STB_GAP    = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Fifo_Empty,
  input  logic [DATA_WIDTH-1:0] i_Fifo_Data,
  output logic                  o_Fifo_Read,
  output logic                  o_Tm_Stb,
  output logic                  o_Tm_Clk,
  output logic                  o_Tm_Dio,
  output logic                  o_Busy
);

  localparam int TIMER_MAX = STB_GAP * CLK_DIV;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(CLK_DIV - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(TIMER_MAX - 1);

  tm_state_e          r_State;
  logic [7:0]         r_Shift;
  logic               r_Last;
  logic [3:0]         r_Bit_Count;
  logic               r_Stb;
  logic               r_Clk_Out;
  logic               r_Dio;
  logic               r_Busy;

  logic               w_Pop;
  logic               w_Timed;
  logic               w_Tick;
  logic               w_Load;
  logic [TIMER_W-1:0] w_Load_Value;

  // Only IDLE and NEXT may pop; reset suppresses the pop so no word is lost.
  assign w_Pop   = ((r_State == S_IDLE) || (r_State == S_NEXT)) && !i_Fifo_Empty && !i_Rst;
  assign w_Timed = (r_State == S_SETUP) || (r_State == S_BIT_LOW) || (r_State == S_BIT_HIGH) ||
                   (r_State == S_STB_END) || (r_State == S_GAP);
  // Every timer tick in a timed state changes state, as does every pop.
  assign w_Load       = w_Pop || (w_Tick && w_Timed);
  assign w_Load_Value = (r_State == S_STB_END) ? GAP_LOAD : HALF_LOAD;

  if (DATA_WIDTH > TM_LAST_BIT + 1) begin : g_spare_bits
    logic w_unused_High;
    assign w_unused_High = ^i_Fifo_Data[DATA_WIDTH-1:TM_LAST_BIT+1];
  end

  tm1638_half_bit_timer #(
    .MAX_COUNT (TIMER_MAX)
  ) u_timer (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Load       (w_Load),
    .i_Load_Value (w_Load_Value),
    .o_Tick       (w_Tick)
  );

  // Bus sequencer: state, shift register and all bus outputs registered together.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State     <= S_IDLE;
      r_Shift     <= '0;
      r_Last      <= 1'b0;
      r_Bit_Count <= '0;
      r_Stb       <= TM_STB_IDLE;
      r_Clk_Out   <= TM_CLK_IDLE;
      r_Dio       <= TM_DIO_IDLE;
      r_Busy      <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: begin
          if (w_Pop) begin
            r_Shift     <= i_Fifo_Data[TM_BYTE_MSB:TM_BYTE_LSB];
            r_Last      <= i_Fifo_Data[TM_LAST_BIT];
            r_Bit_Count <= '0;
            r_Stb       <= 1'b0;
            r_Clk_Out   <= 1'b1;
            r_Dio       <= i_Fifo_Data[TM_BYTE_LSB];
            r_Busy      <= 1'b1;
            r_State     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_Tick) begin
            r_Clk_Out <= 1'b0;
            r_State   <= S_BIT_LOW;
          end
        end
        S_BIT_LOW: begin
          r_Dio <= r_Shift[0];
          if (w_Tick) begin
            r_Clk_Out <= 1'b1;
            r_State   <= S_BIT_HIGH;
          end
        end
        S_BIT_HIGH: begin
          if (w_Tick) begin
            r_Shift <= {1'b1, r_Shift[7:1]};
            if (r_Bit_Count < 4'd8) begin
              r_Bit_Count <= r_Bit_Count + 4'd1;
            end
            if (r_Bit_Count < 4'd7) begin
              r_Clk_Out <= 1'b0;
              r_Dio     <= r_Shift[1];
              r_State   <= S_BIT_LOW;
            end else if (r_Last) begin
              r_Dio   <= TM_DIO_IDLE;
              r_State <= S_STB_END;
            end else begin
              r_Dio   <= TM_DIO_IDLE;
              r_State <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (w_Pop) begin
            r_Shift     <= i_Fifo_Data[TM_BYTE_MSB:TM_BYTE_LSB];
            r_Last      <= i_Fifo_Data[TM_LAST_BIT];
            r_Bit_Count <= '0;
            r_Clk_Out   <= 1'b0;
            r_Dio       <= i_Fifo_Data[TM_BYTE_LSB];
            r_State     <= S_BIT_LOW;
          end
        end
        S_STB_END: begin
          if (w_Tick) begin
            r_Stb   <= TM_STB_IDLE;
            r_State <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_Tick) begin
            r_Busy  <= 1'b0;
            r_State <= S_IDLE;
          end
        end
        default: begin
          r_Stb     <= TM_STB_IDLE;
          r_Clk_Out <= TM_CLK_IDLE;
          r_Dio     <= TM_DIO_IDLE;
          r_Busy    <= 1'b0;
          r_State   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Fifo_Read = w_Pop;
  assign o_Tm_Stb    = r_Stb;
  assign o_Tm_Clk    = r_Clk_Out;
  assign o_Tm_Dio    = r_Dio;
  assign o_Busy      = r_Busy;

endmodule
